// File: rtl/risk_pkg.sv
// Shared defaults and FSM state type for the Monte Carlo batch statistics finalizer.
package risk_pkg;

  localparam int unsigned ACC_W     = 27;
  localparam int unsigned OUT_W     = 18;
  localparam int unsigned LOG2_N    = 10;
  localparam int unsigned FRAC      = 8;
  localparam int unsigned SQ_CYCLES = OUT_W;

  typedef enum logic [2:0] {
    IDLE,
    MEAN,
    SQUARE,
    VAR,
    DONE
  } stateT;

endpackage

// File: rtl/seq_mult_u.sv
// Unsigned W x W shift-add multiplier: one partial product per clock,
// product valid (done pulse) exactly W clocks after the start edge.
module seq_mult_u
  import risk_pkg::*;
#(
  parameter int unsigned W = SQ_CYCLES
) (
  input  logic           clk,
  input  logic           rstN,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [2*W-1:0] product
);

  localparam int unsigned CW = $clog2(W + 1);

  logic [2*W-1:0] aSh;
  logic [W-1:0]   bSh;
  logic [CW-1:0]  cnt;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      aSh     <= '0;
      bSh     <= '0;
      cnt     <= '0;
      product <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        aSh     <= (2*W)'(a);
        bSh     <= b;
        product <= '0;
        cnt     <= CW'(W);
      end else if (cnt != '0) begin
        if (bSh[0]) product <= product + aSh;
        aSh  <= aSh << 1;
        bSh  <= bSh >> 1;
        cnt  <= cnt - CW'(1);
        done <= (cnt == CW'(1));
      end
    end
  end

endmodule

// File: rtl/risk_stats_finalize.sv
// Converts batch accumulators (sum, sum of squares) into mean and clamped
// variance using a single sequential multiplier for mean^2.
module risk_stats_finalize #(
  parameter int unsigned ACC_W  = risk_pkg::ACC_W,
  parameter int unsigned OUT_W  = risk_pkg::OUT_W,
  parameter int unsigned LOG2_N = risk_pkg::LOG2_N,
  parameter int unsigned FRAC   = risk_pkg::FRAC
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             iStart,
  input  logic [ACC_W-1:0] iAcc1,
  input  logic [ACC_W-1:0] iAcc2,
  output logic             oBusy,
  output logic             oValid,
  output logic [OUT_W-1:0] oMean,
  output logic [OUT_W-1:0] oVar,
  output logic             oClamp
);

  import risk_pkg::*;

  localparam int unsigned PW    = 2 * OUT_W;
  localparam int unsigned DW    = PW + 1;
  localparam int unsigned CNT_W = $clog2(OUT_W + 1);
  localparam logic [CNT_W-1:0] SQ_LAST = CNT_W'(OUT_W - 1);

  stateT state, stateNxt;

  logic [ACC_W-1:0] acc1Q, acc2Q;
  logic [OUT_W-1:0] meanQ;
  logic [CNT_W-1:0] sqCnt;

  logic [OUT_W-1:0] meanNow, absMean;
  logic             multStart, multDone;
  logic [PW-1:0]    product;
  logic [DW-1:0]    ex2W, msqW, diff;
  logic             diffNeg, diffOver;
  logic             capture, finish;

  assign meanNow   = OUT_W'($signed(acc1Q) >>> LOG2_N);
  assign absMean   = meanNow[OUT_W-1] ? -meanNow : meanNow;
  assign multStart = (state == MEAN);

  // Both operands are unsigned and fit in DW bits, so the MSB of the
  // difference is a reliable sign.
  assign ex2W     = DW'(acc2Q >> LOG2_N);
  assign msqW     = DW'(product >> FRAC);
  assign diff     = ex2W - msqW;
  assign diffNeg  = diff[DW-1];
  assign diffOver = |diff[PW-1:OUT_W];

  assign capture = iStart && ((state == IDLE) || (state == DONE));
  assign finish  = (state == VAR) && multDone;
  assign oBusy   = (state != IDLE);

  seq_mult_u #(.W(OUT_W)) uMult (
    .clk     (CLK),
    .rstN    (RST_N),
    .start   (multStart),
    .a       (absMean),
    .b       (absMean),
    .done    (multDone),
    .product (product)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    unique case (state)
      IDLE:    if (iStart) stateNxt = MEAN;
      MEAN:    stateNxt = SQUARE;
      SQUARE:  if (sqCnt == SQ_LAST) stateNxt = VAR;
      VAR:     if (multDone) stateNxt = DONE;
      DONE:    stateNxt = iStart ? MEAN : IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      acc1Q  <= '0;
      acc2Q  <= '0;
      meanQ  <= '0;
      sqCnt  <= '0;
      oValid <= 1'b0;
      oMean  <= '0;
      oVar   <= '0;
      oClamp <= 1'b0;
    end else begin
      oValid <= 1'b0;
      if (capture) begin
        acc1Q <= iAcc1;
        acc2Q <= iAcc2;
      end
      if (state == MEAN) begin
        meanQ <= meanNow;
        sqCnt <= '0;
      end
      if (state == SQUARE) sqCnt <= sqCnt + 1'b1;
      if (finish) begin
        oValid <= 1'b1;
        oMean  <= meanQ;
        oClamp <= diffNeg;
        oVar   <= diffNeg ? '0 : (diffOver ? '1 : diff[OUT_W-1:0]);
      end
    end
  end

endmodule
